dsp_frame_sequencer: RTL and testbench

Synthesisable per-sample frame controller that sits between the audio converters and DSPCore. It generates the one-cycle start pulse for each audio sample, from an internal divider or an external strobe. It presents a stable multi-channel input frame to the core, waits a fixed run length, then captures the core outputs as one output frame. It also counts samples and flags overruns, which replaces hand-driven start/inputs sequencing.

---
 rtl/dsp_frame_sequencer.sv | 97 +++++++++
 tb/tb_dsp_frame_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dsp_frame_sequencer.sv
// Per-sample frame controller in front of DSPCore: derives a sample tick from
// an internal divider or an external strobe, presents a stable input frame,
// waits for the core run length, then captures the core outputs as one frame.
module dsp_frame_sequencer #(
  parameter int WIDTH             = 36,
  parameter int CHANNELS          = 8,
  parameter int CYCLES_PER_SAMPLE = 2083,
  parameter int RUN_CYCLES        = 50
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      ext_mode,
  input  logic                      sample_strobe,
  input  logic                      adc_valid,
  input  logic [CHANNELS*WIDTH-1:0] adc_data,
  output logic                      core_start,
  output logic [CHANNELS*WIDTH-1:0] core_inputs,
  input  logic [CHANNELS*WIDTH-1:0] core_outputs,
  output logic [CHANNELS*WIDTH-1:0] dac_data,
  output logic                      dac_valid,
  output logic                      busy,
  output logic                      overrun,
  input  logic                      clear_overrun,
  output logic [31:0]               sample_count
);

  localparam int FW = CHANNELS * WIDTH;
  localparam int DW = (CYCLES_PER_SAMPLE > 1) ? $clog2(CYCLES_PER_SAMPLE) : 1;
  localparam int RW = $clog2(RUN_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, START, RUN, CAPTURE} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div;
  logic [RW-1:0] run_cnt;
  logic [FW-1:0] staging;
  logic          int_tick, tick, run_done;

  assign int_tick = enable && !ext_mode && (div == DW'(CYCLES_PER_SAMPLE - 1));
  assign tick     = enable && (ext_mode ? sample_strobe : int_tick);
  assign run_done = (state == RUN) && (run_cnt == RW'(RUN_CYCLES - 1));

  // Outputs decode the state register only, so no input reaches them combinationally.
  assign core_start = (state == START);
  assign dac_valid  = (state == CAPTURE);
  assign busy       = (state != IDLE);

  // Sample-period divider; held at 0 whenever internal ticking is not selected.
  always_ff @(posedge clk) begin
    if (reset || !enable || ext_mode) div <= '0;
    else if (int_tick)                div <= '0;
    else                              div <= div + DW'(1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: one frame per accepted tick, fixed run length.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick) state_nxt = START;
      START:   state_nxt = RUN;
      RUN:     if (run_done) state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame datapath, run counter, frame counter and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      staging      <= '0;
      core_inputs  <= '0;
      dac_data     <= '0;
      run_cnt      <= '0;
      sample_count <= '0;
      overrun      <= 1'b0;
    end else begin
      if (adc_valid) staging <= adc_data;
      // Fresh ADC data in the tick cycle wins over the staged frame.
      if (state == IDLE && tick) core_inputs <= adc_valid ? adc_data : staging;
      if (state == START)    run_cnt <= '0;
      else if (state == RUN) run_cnt <= run_cnt + RW'(1);
      if (run_done) dac_data <= core_outputs;
      if (state == CAPTURE) sample_count <= sample_count + 32'd1;
      // A tick while a frame is in flight is dropped; set beats clear.
      if (tick && state != IDLE) overrun <= 1'b1;
      else if (clear_overrun)    overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dsp_frame_sequencer.sv
// Bench for dsp_frame_sequencer: directed scenarios followed by random traffic,
// every cycle compared against a timestamp-based frame model.
module tb_dsp_frame_sequencer;

  localparam int W   = 36;
  localparam int C   = 8;
  localparam int CPS = 100;
  localparam int RC  = 50;
  localparam int FW  = W * C;

  logic          clk, reset, enable, ext_mode, sample_strobe, adc_valid, clear_overrun;
  logic [FW-1:0] adc_data, core_inputs, core_outputs, dac_data;
  logic          core_start, dac_valid, busy, overrun;
  logic [31:0]   sample_count;

  dsp_frame_sequencer #(.WIDTH(W), .CHANNELS(C), .CYCLES_PER_SAMPLE(CPS), .RUN_CYCLES(RC)) dut (
    .clk(clk), .reset(reset), .enable(enable), .ext_mode(ext_mode),
    .sample_strobe(sample_strobe), .adc_valid(adc_valid), .adc_data(adc_data),
    .core_start(core_start), .core_inputs(core_inputs), .core_outputs(core_outputs),
    .dac_data(dac_data), .dac_valid(dac_valid), .busy(busy), .overrun(overrun),
    .clear_overrun(clear_overrun), .sample_count(sample_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core stub: every channel word plus one.
  function automatic logic [FW-1:0] stub_f(input logic [FW-1:0] x);
    logic [FW-1:0] r;
    r = '0;
    for (int i = 0; i < C; i++) r[i*W +: W] = x[i*W +: W] + W'(1);
    return r;
  endfunction

  always_comb core_outputs = stub_f(core_inputs);

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    f = '0;
    for (int i = 0; i < (FW + 31) / 32; i++) f = (f << 32) | FW'($urandom);
    return f;
  endfunction

  int vectors = 0;
  int errors  = 0;

  // Model: a frame is a pair of timestamps (start pulse, capture pulse).
  int            cyc, m_start, m_dac, m_phase;
  bit            m_act;
  logic [FW-1:0] m_in, m_stg, m_dacd;
  logic [31:0]   m_cnt;
  logic          m_ov;

  task automatic model_reset();
    m_act = 0; m_start = -1; m_dac = -1; m_phase = 0;
    m_in = '0; m_stg = '0; m_dacd = '0; m_cnt = '0; m_ov = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: compare outputs for this cycle, drive inputs, advance the model.
  task automatic step(input bit en, input bit ext, input bit strb, input bit av,
                      input logic [FW-1:0] ad, input bit clr, input bit rst);
    bit inflight, itick, tk;
    inflight = m_act && cyc >= m_start && cyc <= m_dac;
    chk("core_start",   core_start,   FW'(m_act && cyc == m_start));
    chk("dac_valid",    dac_valid,    FW'(m_act && cyc == m_dac));
    chk("busy",         busy,         FW'(inflight));
    chk("overrun",      overrun,      FW'(m_ov));
    chk("sample_count", sample_count, FW'(m_cnt));
    chk("core_inputs",  core_inputs,  m_in);
    chk("dac_data",     dac_data,     m_dacd);
    enable = en; ext_mode = ext; sample_strobe = strb; adc_valid = av;
    adc_data = ad; clear_overrun = clr; reset = rst;
    if (rst) begin
      model_reset();
    end else begin
      itick = en && !ext && (m_phase % CPS == CPS - 1);
      m_phase = (en && !ext) ? m_phase + 1 : 0;
      tk = en && (ext ? strb : itick);
      if (m_act && cyc == m_dac - 1) m_dacd = stub_f(m_in);
      if (m_act && cyc == m_dac) m_cnt = m_cnt + 32'd1;
      if (tk && !inflight) begin
        m_in = av ? ad : m_stg;
        m_start = cyc + 1; m_dac = cyc + 2 + RC; m_act = 1;
      end else if (tk) m_ov = 1'b1;
      else if (clr)    m_ov = 1'b0;
      if (av) m_stg = ad;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n, input bit en, input bit ext);
    for (int i = 0; i < n; i++) step(en, ext, 0, 0, '0, 0, 0);
  endtask

  logic [FW-1:0] fd, fa, fb;

  initial begin
    reset = 1'b1; enable = 0; ext_mode = 0; sample_strobe = 0;
    adc_valid = 0; adc_data = '0; clear_overrun = 0;
    repeat (2) @(posedge clk);
    #1;
    cyc = 0;
    model_reset();
    chk("rst_busy",  busy, '0);
    chk("rst_count", sample_count, '0);

    for (int i = 0; i < C; i++) fd[i*W +: W] = 36'h0_2000_0000 + W'(i);

    // Internal mode from cycle 0; one staged ADC frame at cycle 5.
    idle(5, 1, 0);
    step(1, 0, 0, 1, fd, 0, 0);
    idle(94, 1, 0);
    chk("start_at_100", core_start, FW'(1));
    chk("inputs_staged", core_inputs, fd);
    idle(51, 1, 0);
    chk("dvalid_at_151", dac_valid, FW'(1));
    chk("dac_plus_one", dac_data, stub_f(fd));
    idle(201, 1, 0);
    chk("count_3", sample_count, FW'(3));
    chk("no_overrun", overrun, '0);
    idle(10, 0, 0);

    // External strobe with bypass: new data in the strobe cycle beats staging.
    fa = rand_frame(); fb = rand_frame();
    step(1, 1, 0, 1, fb, 0, 0);
    idle(3, 1, 1);
    step(1, 1, 1, 1, fa, 0, 0);
    chk("bypass", core_inputs, fa);
    idle(60, 1, 1);

    // Overrun: strobes 30 apart, third strobe meets a clear, then a lone clear.
    step(1, 1, 1, 0, '0, 0, 0);
    idle(29, 1, 1);
    step(1, 1, 1, 0, '0, 0, 0);
    chk("ovr_set", overrun, FW'(1));
    idle(9, 1, 1);
    step(1, 1, 1, 0, '0, 1, 0);
    chk("ovr_set_wins", overrun, FW'(1));
    idle(4, 1, 1);
    step(1, 1, 0, 0, '0, 1, 0);
    chk("ovr_cleared", overrun, '0);
    idle(20, 1, 1);

    // Reset while the run counter is at 20.
    step(1, 1, 1, 0, '0, 0, 0);
    idle(21, 1, 1);
    step(1, 1, 0, 0, '0, 0, 1);
    chk("rst_mid_busy",  busy, '0);
    chk("rst_mid_count", sample_count, '0);
    chk("rst_mid_dac",   dac_data, '0);
    idle(60, 1, 1);
    step(1, 1, 1, 1, fa, 0, 0);
    idle(RC + 1, 1, 1);
    chk("clean_frame", dac_valid, FW'(1));
    idle(5, 1, 1);

    // Enable dropped during RUN (run counter 10), then re-enabled.
    idle(111, 1, 0);
    idle(150, 0, 0);
    idle(100, 1, 0);
    chk("reenable_start", core_start, FW'(1));
    idle(60, 1, 0);

    // Random traffic.
    begin
      bit ext;
      ext = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 199) == 0) ext = ~ext;
        step($urandom_range(0, 15) != 0, ext, $urandom_range(0, 39) == 0,
             $urandom_range(0, 3) == 0, rand_frame(), $urandom_range(0, 29) == 0,
             $urandom_range(0, 499) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
